adc_scheduler: RTL and testbench

Shares one ADC conversion unit between up to `NREQ` requesters, such as PID loops that each need a sampled measurement. It arbitrates requests round-robin and routes the winner's analog word to the ADC. It sequences the ADC's start / EOC / OE handshake, captures the 12-bit result and returns it to the winner with a one-cycle acknowledge. A watchdog aborts conversions whose EOC handshake stalls.

---
 rtl/adc_scheduler.sv | 177 +++++++++++++++++
 tb/tb_adc_scheduler.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/adc_scheduler.sv
// rtl/adc_scheduler.sv - round-robin sharing of one ADC between NREQ requesters
// Sequences start/EOC/OE, captures the result, acks the winner; watchdog aborts stalled EOC waits.
module adc_scheduler #(
    parameter int NREQ      = 4,
    parameter int AW        = 32,
    parameter int DW        = 12,
    parameter int START_CYC = 1,
    parameter int TIMEOUT   = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] ana_in,
    output logic [NREQ-1:0]    ack,
    output logic               err,
    output logic [DW-1:0]      rdata,
    output logic [2:0]         grant_id,
    output logic               busy,
    output logic [AW-1:0]      adc_anadata,
    output logic               adc_start,
    output logic               adc_oe,
    input  logic               adc_eoc,
    input  logic [DW-1:0]      adc_data
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_WAIT_LO, S_WAIT_HI, S_OE, S_DONE
    } state_t;

    // One counter serves the start hold, the watchdog and the OE hold.
    localparam int CW = $clog2(TIMEOUT + 16 + 1);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              err_q, err_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic [2:0]        grant_id_q, grant_id_d;
    logic              busy_q, busy_d;
    logic [AW-1:0]     anadata_q, anadata_d;
    logic              start_q, start_d;
    logic              oe_q, oe_d;

    logic              found;
    logic [2:0]        win;
    int                idx;
    logic [NREQ-1:0]   grant_onehot;

    assign grant_onehot = NREQ'(1) << grant_id_q;

    // First set request at or above the pointer, wrapping past NREQ-1.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = 3'(idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        ack_d      = ack_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        grant_id_d = grant_id_q;
        busy_d     = busy_q;
        anadata_d  = anadata_q;
        start_d    = start_q;
        oe_d       = oe_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    grant_id_d = win;
                    anadata_d  = ana_in[int'(win)*AW +: AW];
                    busy_d     = 1'b1;
                    start_d    = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (cnt_q == CW'(START_CYC - 1)) begin
                    start_d = 1'b0;
                    cnt_d   = '0;
                    state_d = S_WAIT_LO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_LO, S_WAIT_HI: begin
                if ((state_q == S_WAIT_LO) && !adc_eoc) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_HI;
                end else if ((state_q == S_WAIT_HI) && adc_eoc) begin
                    oe_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = S_OE;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    start_d = 1'b0;
                    oe_d    = 1'b0;
                    ack_d   = grant_onehot;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_OE: begin
                // Data settles on the first OE edge; capture on the second.
                if (cnt_q == CW'(1)) begin
                    rdata_d = adc_data;
                    oe_d    = 1'b0;
                    ack_d   = grant_onehot;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                ack_d   = '0;
                err_d   = 1'b0;
                busy_d  = 1'b0;
                ptr_d   = (grant_id_q == 3'(NREQ - 1)) ? 3'd0 : grant_id_q + 3'd1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ptr_q      <= '0;
            ack_q      <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
            anadata_q  <= '0;
            start_q    <= 1'b0;
            oe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
            anadata_q  <= anadata_d;
            start_q    <= start_d;
            oe_q       <= oe_d;
        end
    end

    assign ack         = ack_q;
    assign err         = err_q;
    assign rdata       = rdata_q;
    assign grant_id    = grant_id_q;
    assign busy        = busy_q;
    assign adc_anadata = anadata_q;
    assign adc_start   = start_q;
    assign adc_oe      = oe_q;

endmodule

// File: tb/tb_adc_scheduler.sv
// tb/tb_adc_scheduler.sv - directed bench for adc_scheduler with a 10-cycle ADC model
module tb_adc_scheduler;

    localparam int NREQ = 4;
    localparam int AW   = 32;
    localparam int DW   = 12;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] ana_in;
    logic [NREQ-1:0]    ack;
    logic               err;
    logic [DW-1:0]      rdata;
    logic [2:0]         grant_id;
    logic               busy;
    logic [AW-1:0]      adc_anadata;
    logic               adc_start;
    logic               adc_oe;
    logic               adc_eoc;
    logic [DW-1:0]      adc_data;

    logic               stuck;
    int                 conv;
    int                 checks = 0;
    int                 errors = 0;

    adc_scheduler #(.NREQ(NREQ), .AW(AW), .DW(DW), .START_CYC(1), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .req(req), .ana_in(ana_in), .ack(ack), .err(err),
        .rdata(rdata), .grant_id(grant_id), .busy(busy), .adc_anadata(adc_anadata),
        .adc_start(adc_start), .adc_oe(adc_oe), .adc_eoc(adc_eoc), .adc_data(adc_data)
    );

    always #5 clk = ~clk;

    // ADC model: EOC low for 10 cycles after start; data = low 12 bits of anadata on OE.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            adc_eoc  <= 1'b1;
            conv     <= 0;
            adc_data <= '0;
        end else begin
            if (adc_oe) adc_data <= adc_anadata[DW-1:0];
            if (stuck) begin
                adc_eoc <= 1'b1;
            end else if (conv != 0) begin
                conv <= conv - 1;
                if (conv == 1) adc_eoc <= 1'b1;
            end else if (adc_start && adc_eoc) begin
                adc_eoc <= 1'b0;
                conv    <= 10;
            end
        end
    end

    typedef struct {
        logic [NREQ-1:0] req;
        int              idx;
        logic [DW-1:0]   data;
    } vec_t;

    vec_t          tbl[10];
    logic [DW-1:0] lo[4];
    logic [DW-1:0] last_rdata;
    int            n;
    int            extra;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ack(input string name, output int cycles);
        cycles = 0;
        while (ack == '0 && cycles < 300) begin
            @(negedge clk);
            cycles++;
        end
        if (ack == '0) begin
            checks++;
            errors++;
            $display("FAIL %s: got no ack within 300 cycles, expected an ack", name);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"}, 32'(ack), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_rdata"}, 32'(rdata), 32'd0);
        check({tag, "_grant_id"}, 32'(grant_id), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_anadata"}, adc_anadata, 32'd0);
        check({tag, "_start"}, 32'(adc_start), 32'd0);
        check({tag, "_oe"}, 32'(adc_oe), 32'd0);
    endtask

    initial begin
        lo = '{12'h111, 12'h222, 12'hABC, 12'hD44};
        tbl[0] = '{4'b1111, 0, 12'h111};
        tbl[1] = '{4'b1111, 1, 12'h222};
        tbl[2] = '{4'b1111, 2, 12'hABC};
        tbl[3] = '{4'b1111, 3, 12'hD44};
        tbl[4] = '{4'b1111, 0, 12'h111};
        tbl[5] = '{4'b1001, 3, 12'hD44};
        tbl[6] = '{4'b1001, 0, 12'h111};
        tbl[7] = '{4'b1001, 3, 12'hD44};
        tbl[8] = '{4'b0100, 2, 12'hABC};
        tbl[9] = '{4'b0010, 1, 12'h222};

        rst   = 1'b1;
        req   = '0;
        stuck = 1'b0;
        ana_in[0*AW +: AW] = 32'h1234_5111;
        ana_in[1*AW +: AW] = 32'hFFFF_F222;
        ana_in[2*AW +: AW] = 32'h0000_0ABC;
        ana_in[3*AW +: AW] = 32'hDEAD_0D44;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Round-robin, fairness and single-request rows.
        for (int i = 0; i < 10; i++) begin
            req = tbl[i].req;
            @(negedge clk);
            wait_ack($sformatf("row%0d_wait", i), n);
            check($sformatf("row%0d_ack", i), 32'(ack), 32'(1) << tbl[i].idx);
            check($sformatf("row%0d_rdata", i), 32'(rdata), 32'(tbl[i].data));
            check($sformatf("row%0d_err", i), 32'(err), 32'd0);
            last_rdata = tbl[i].data;
        end
        req = '0;
        @(negedge clk);
        check("done_busy_low", 32'(busy), 32'd0);
        check("done_ack_low", 32'(ack), 32'd0);

        // Watchdog: EOC never falls; pointer is 2 so requester 3 wins.
        stuck = 1'b1;
        req   = 4'b1000;
        @(negedge clk);
        check("wd_busy", 32'(busy), 32'd1);
        wait_ack("wd_wait", n);
        check("wd_latency", 32'(n), 32'd66);
        check("wd_ack", 32'(ack), 32'b1000);
        check("wd_err", 32'(err), 32'd1);
        check("wd_rdata_kept", 32'(rdata), 32'(last_rdata));
        check("wd_start", 32'(adc_start), 32'd0);
        check("wd_oe", 32'(adc_oe), 32'd0);
        req   = '0;
        stuck = 1'b0;
        @(negedge clk);

        // Reset during WAIT_HI, then requester 1 served from pointer 0.
        req = 4'b1010;
        n = 0;
        while (adc_eoc && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rst_eoc_fell", 32'(adc_eoc), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        check("midrst_ack_hold", 32'(ack), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_grant", 32'(grant_id), 32'd1);
        wait_ack("post_rst_wait", n);
        check("post_rst_ack", 32'(ack), 32'b0010);
        check("post_rst_rdata", 32'(rdata), 32'(lo[1]));
        check("post_rst_err", 32'(err), 32'd0);
        req = '0;
        @(negedge clk);

        // Request dropped and analog word changed right after grant.
        ana_in[1*AW +: AW] = 32'h0BAD_05A5;
        req = 4'b0010;
        @(negedge clk);
        check("drop_busy", 32'(busy), 32'd1);
        check("drop_grant", 32'(grant_id), 32'd1);
        req = '0;
        ana_in[1*AW +: AW] = 32'h0000_0777;
        wait_ack("drop_wait", n);
        check("drop_ack", 32'(ack), 32'b0010);
        check("drop_rdata", 32'(rdata), 32'h5A5);
        check("drop_err", 32'(err), 32'd0);
        extra = 0;
        @(negedge clk);
        repeat (40) begin
            @(negedge clk);
            if (ack != '0 || busy) extra++;
        end
        check("drop_no_regrant", 32'(extra), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
